// File: rtl/mux_32_pkg.sv
// Datapath select constants shared between the word selectors and the
// control unit that drives their op inputs.
package mux_32_pkg;

    // op encoding: which data word a selector forwards
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

endpackage : mux_32_pkg

// File: rtl/mux_32.sv
// Two-input word selector for the CPU datapath (operand B, write-back and
// PC-source selects). Combinational by default; REGISTERED=1 adds one output
// register stage with a synchronous, active-high reset to RESET_VALUE.
// clk and rst are present in every configuration so all instances share
// one port list.
module mux_32
    import mux_32_pkg::*;
#(
    parameter int unsigned          WIDTH       = 32,
    parameter bit                   REGISTERED  = 1'b0,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             op,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] sel_d;

    // Word select; an unknown op yields an unknown word rather than
    // silently defaulting to input1.
    always_comb begin
        sel_d = '0;
        case (op)
            SEL_IN1: sel_d = input1;
            SEL_IN2: sel_d = input2;
            default: sel_d = 'x;
        endcase
    end

    generate
        if (REGISTERED) begin : g_registered
            logic [WIDTH-1:0] out_d;
            logic [WIDTH-1:0] out_q;

            // Next register value: reset wins over the current selection.
            always_comb begin
                out_d = sel_d;
                if (rst) begin
                    out_d = RESET_VALUE;
                end
            end

            // Output pipeline register.
            always_ff @(posedge clk) begin
                out_q <= out_d;
            end

            assign out = out_q;
        end else begin : g_combinational
            // clk, rst and RESET_VALUE are intentionally unused here.
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, RESET_VALUE};

            assign out = sel_d;
        end
    endgenerate

endmodule : mux_32

// File: tb/tb_mux_32.sv
// Self-checking bench for mux_32: one combinational instance and two
// registered instances (zero and non-zero reset values) driven in parallel.
module tb_mux_32;

    localparam int unsigned    W       = 32;
    localparam logic [W-1:0]   RV_ALT  = 32'hDEAD_BEEF;

    logic         clk;
    logic         rst;
    logic [W-1:0] input1;
    logic [W-1:0] input2;
    logic         op;
    logic [W-1:0] out_c;
    logic [W-1:0] out_r0;
    logic [W-1:0] out_rv;

    int vectors;
    int miscompares;

    mux_32 #(.WIDTH(W), .REGISTERED(1'b0), .RESET_VALUE('0)) u_comb (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2), .op(op), .out(out_c)
    );

    mux_32 #(.WIDTH(W), .REGISTERED(1'b1), .RESET_VALUE('0)) u_reg0 (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2), .op(op), .out(out_r0)
    );

    mux_32 #(.WIDTH(W), .REGISTERED(1'b1), .RESET_VALUE(RV_ALT)) u_regv (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2), .op(op), .out(out_rv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rule: op low forwards input1, op high forwards input2.
    function automatic logic [W-1:0] ref_sel(input logic s, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        return s ? b : a;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_r0;
        logic [W-1:0] exp_rv;
        logic [W-1:0] nxt_r0;
        logic [W-1:0] nxt_rv;
        logic [W-1:0] word;

        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        op     = 1'b0;
        input1 = '0;
        input2 = '0;

        // Combinational: alternating patterns
        input1 = 32'hAAAA_AAAA; input2 = 32'h5555_5555; op = 1'b0; #1;
        check("comb_aa_op0", out_c, 32'hAAAA_AAAA);
        op = 1'b1; #1;
        check("comb_55_op1", out_c, 32'h5555_5555);

        // Combinational: extreme patterns
        input1 = 32'hFFFF_FFFF; input2 = 32'h0000_0000; op = 1'b0; #1;
        check("comb_ones_op0", out_c, 32'hFFFF_FFFF);
        op = 1'b1; #1;
        check("comb_zeros_op1", out_c, 32'h0000_0000);

        // Combinational: walking one on input2, input1 churn must not leak
        op = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            word   = '0;
            word[i] = 1'b1;
            input2 = word;
            input1 = $urandom;
            #1;
            check("comb_walk", out_c, word);
            input1 = ~input1;
            #1;
            check("comb_walk_in1_churn", out_c, word);
        end

        // Combinational: random vectors
        for (int i = 0; i < 24; i++) begin
            input1 = $urandom; input2 = $urandom; op = 1'($urandom);
            #1;
            check("comb_random", out_c, ref_sel(op, input1, input2));
        end

        // Registered: two cycles of reset
        rst = 1'b1; input1 = $urandom; input2 = $urandom; op = 1'b0;
        tick();
        tick();
        check("reg0_reset", out_r0, 32'h0000_0000);
        check("regv_reset", out_rv, RV_ALT);

        // Release reset with op=1: must not appear before the next edge
        rst = 1'b0; op = 1'b1; input2 = 32'h1234_5678; #1;
        check("reg0_hold_before_edge", out_r0, 32'h0000_0000);
        check("regv_hold_before_edge", out_rv, RV_ALT);
        tick();
        check("reg0_first_load", out_r0, 32'h1234_5678);
        check("regv_first_load", out_rv, 32'h1234_5678);

        // Reset in the same cycle as an op/data change
        rst = 1'b1; op = 1'b0; input1 = $urandom; input2 = $urandom;
        tick();
        check("reg0_rst_dominates", out_r0, 32'h0000_0000);
        check("regv_rst_dominates", out_rv, RV_ALT);
        exp_r0 = '0;
        exp_rv = RV_ALT;

        // Toggling op with random data and sporadic mid-stream reset
        op = 1'b1;
        for (int i = 0; i < 40; i++) begin
            input1 = $urandom;
            input2 = $urandom;
            op     = ~op;
            rst    = ($urandom_range(0, 5) == 0);
            #1;
            check("reg0_lag_hold", out_r0, exp_r0);
            check("regv_lag_hold", out_rv, exp_rv);
            check("comb_in_stream", out_c, ref_sel(op, input1, input2));
            nxt_r0 = rst ? '0     : ref_sel(op, input1, input2);
            nxt_rv = rst ? RV_ALT : ref_sel(op, input1, input2);
            tick();
            check("reg0_lag_load", out_r0, nxt_r0);
            check("regv_lag_load", out_rv, nxt_rv);
            exp_r0 = nxt_r0;
            exp_rv = nxt_rv;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mux_32
